// File: rtl/acs_scheduler_pkg.sv
// acs_pkg: shared FSM encoding and default operand width for the ACS scheduler.
package acs_pkg;
   localparam int W_DEF = 4;
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
endpackage

// File: rtl/acs_scheduler_if.sv
// acs_scheduler_if: request, shared add/sub unit and response signals of the ACS scheduler.
interface acs_scheduler_if #(parameter int W = acs_pkg::W_DEF);
   logic         req0_valid, req1_valid;
   logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
   logic         req0_sel, req1_sel;
   logic         req0_ready, req1_ready;
   logic [W-1:0] acs_a, acs_b, acs_out;
   logic         acs_sel, acs_cob;
   logic         rsp_valid, rsp_id, rsp_cob, rsp_ready;
   logic [W-1:0] rsp_out;
   modport master (
      output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, req0_sel, req1_sel,
      input  req0_ready, req1_ready,
      input  acs_a, acs_b, acs_sel,
      output acs_out, acs_cob,
      input  rsp_valid, rsp_id, rsp_out, rsp_cob,
      output rsp_ready
   );
   modport slave (
      input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, req0_sel, req1_sel,
      output req0_ready, req1_ready,
      output acs_a, acs_b, acs_sel,
      input  acs_out, acs_cob,
      output rsp_valid, rsp_id, rsp_out, rsp_cob,
      input  rsp_ready
   );
endinterface

// File: rtl/acs_scheduler_rr_arb2.sv
// rr_arb2: two-way round-robin pick; the pointer names the preferred requester.
module rr_arb2 (
   input  logic [1:0] valid_i,
   input  logic       ptr_i,
   output logic [1:0] gnt_o
);
   assign gnt_o[0] = valid_i[0] & (~ptr_i | ~valid_i[1]);
   assign gnt_o[1] = valid_i[1] & (ptr_i | ~valid_i[0]);
endmodule

// File: rtl/acs_scheduler.sv
// acs_scheduler: arbitrates two requesters onto one external add/sub unit and holds
// each result until the consumer takes it; counts grants per requester.
module acs_scheduler
   import acs_pkg::*;
#(
   parameter int W     = W_DEF,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   acs_scheduler_if.slave   bus,
   output logic [CNT_W-1:0] gnt_cnt0,
   output logic [CNT_W-1:0] gnt_cnt1
);
   state_e           state_q, state_d;
   logic             ptr_q, ptr_d, id_q, id_d, sel_q, sel_d, cob_q, cob_d;
   logic [W-1:0]     a_q, a_d, b_q, b_d, out_q, out_d;
   logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
   logic [1:0]       gnt, rdy;

   rr_arb2 u_arb (
      .valid_i({bus.req1_valid, bus.req0_valid}),
      .ptr_i  (ptr_q),
      .gnt_o  (gnt)
   );

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      id_d    = id_q;
      a_d     = a_q;
      b_d     = b_q;
      sel_d   = sel_q;
      out_d   = out_q;
      cob_d   = cob_q;
      cnt0_d  = cnt0_q;
      cnt1_d  = cnt1_q;
      rdy     = 2'b00;
      case (state_q)
         IDLE: begin
            rdy = gnt & {2{rst_n}};
            if (|gnt) begin
               state_d = EXEC;
               id_d    = gnt[1];
               a_d     = gnt[1] ? bus.req1_a : bus.req0_a;
               b_d     = gnt[1] ? bus.req1_b : bus.req0_b;
               sel_d   = gnt[1] ? bus.req1_sel : bus.req0_sel;
               cnt0_d  = cnt0_q + CNT_W'(gnt[0] & ~&cnt0_q);
               cnt1_d  = cnt1_q + CNT_W'(gnt[1] & ~&cnt1_q);
            end
         end
         EXEC: begin
            out_d   = bus.acs_out;
            cob_d   = bus.acs_cob;
            state_d = RESP;
         end
         RESP: begin
            // the requester just served yields priority to the other one
            if (bus.rsp_ready) begin
               state_d = IDLE;
               ptr_d   = ~id_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= 1'b0;
         id_q    <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sel_q   <= 1'b0;
         out_q   <= '0;
         cob_q   <= 1'b0;
         cnt0_q  <= '0;
         cnt1_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sel_q   <= sel_d;
         out_q   <= out_d;
         cob_q   <= cob_d;
         cnt0_q  <= cnt0_d;
         cnt1_q  <= cnt1_d;
      end
   end

   assign bus.req0_ready = rdy[0];
   assign bus.req1_ready = rdy[1];
   assign bus.acs_a      = a_q;
   assign bus.acs_b      = b_q;
   assign bus.acs_sel    = sel_q;
   assign bus.rsp_valid  = state_q == RESP;
   assign bus.rsp_id     = id_q;
   assign bus.rsp_out    = out_q;
   assign bus.rsp_cob    = cob_q;
   assign gnt_cnt0       = cnt0_q;
   assign gnt_cnt1       = cnt1_q;
endmodule

// File: tb/tb_acs_scheduler.sv
// tb_acs_scheduler: directed and random checks of acs_scheduler against a
// transaction-level model of arbitration, latency, results and grant counts.
module tb_acs_scheduler;
   logic       clk, rst_n;
   logic [7:0] cnt0, cnt1;
   logic [1:0] s_cnt0, s_cnt1;
   int         n_chk = 0, n_fail = 0;
   int         log_q[$];

   acs_scheduler_if #(.W(4)) bus ();
   acs_scheduler_if #(.W(4)) bus2 ();

   acs_scheduler #(.W(4), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .gnt_cnt0(cnt0), .gnt_cnt1(cnt1)
   );
   acs_scheduler #(.W(4), .CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .bus(bus2), .gnt_cnt0(s_cnt0), .gnt_cnt1(s_cnt1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // external add/sub unit: 5-bit sum/difference, top bit is carry or borrow
   always_comb begin
      logic [4:0] r;
      r = bus.acs_sel ? {1'b0, bus.acs_a} - {1'b0, bus.acs_b} : {1'b0, bus.acs_a} + {1'b0, bus.acs_b};
      {bus.acs_cob, bus.acs_out} = r;
   end
   always_comb begin
      logic [4:0] r;
      r = bus2.acs_sel ? {1'b0, bus2.acs_a} - {1'b0, bus2.acs_b} : {1'b0, bus2.acs_a} + {1'b0, bus2.acs_b};
      {bus2.acs_cob, bus2.acs_out} = r;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // reference model: phase 0 idle, 1 executing, 2 response held
   int  phase = 0, cnt_m0 = 0, cnt_m1 = 0, ea, eb, esel, eid, eout, ecob;
   bit  ptr_m = 0;
   always @(negedge clk) begin
      logic [1:0] v;
      int win;
      if (!rst_n) begin
         phase = 0; ptr_m = 0; cnt_m0 = 0; cnt_m1 = 0;
         check("rdy_in_rst", {bus.req1_ready, bus.req0_ready}, 0);
      end else begin
         check("cnt0", cnt0, cnt_m0);
         check("cnt1", cnt1, cnt_m1);
         v = {bus.req1_valid, bus.req0_valid};
         if (phase == 0) begin
            win = v[ptr_m] ? int'(ptr_m) : int'(!ptr_m);
            check("ready", {bus.req1_ready, bus.req0_ready}, v == 0 ? 0 : (win == 1 ? 2 : 1));
            if (v != 0) begin
               eid  = win;
               ea   = win ? bus.req1_a : bus.req0_a;
               eb   = win ? bus.req1_b : bus.req0_b;
               esel = win ? bus.req1_sel : bus.req0_sel;
               eout = esel ? (ea - eb + 16) % 16 : (ea + eb) % 16;
               ecob = esel ? int'(ea < eb) : int'(ea + eb > 15);
               if (win == 0) cnt_m0 = cnt_m0 < 255 ? cnt_m0 + 1 : 255;
               else          cnt_m1 = cnt_m1 < 255 ? cnt_m1 + 1 : 255;
               phase = 1;
            end
         end else begin
            check("ready_busy", {bus.req1_ready, bus.req0_ready}, 0);
            check("acs_ops", {bus.acs_sel, bus.acs_a, bus.acs_b}, {esel[0], ea[3:0], eb[3:0]});
            check("rsp_valid", bus.rsp_valid, phase == 2);
            if (phase == 2) begin
               check("rsp_fields", {bus.rsp_id, bus.rsp_cob, bus.rsp_out}, {eid[0], ecob[0], eout[3:0]});
               if (bus.rsp_ready) begin
                  ptr_m = eid == 0;
                  log_q.push_back(eid);
                  phase = 0;
               end
            end else phase = 2;
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      rst_n = 1'b0;
      #2;
      check("rst_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_cob, bus.rsp_out}, 0);
      check("rst_acs", {bus.acs_sel, bus.acs_a, bus.acs_b}, 0);
      check("rst_cnt", {cnt0, cnt1}, 0);
      check("rst_rdy", {bus.req1_ready, bus.req0_ready}, 0);
      step(2);
      rst_n = 1'b1;
   endtask

   task automatic do_op(input int id, input int a, input int b, input int sel, input int eo, input int ec);
      if (id == 0) begin bus.req0_valid = 1; bus.req0_a = 4'(a); bus.req0_b = 4'(b); bus.req0_sel = sel[0]; end
      else         begin bus.req1_valid = 1; bus.req1_a = 4'(a); bus.req1_b = 4'(b); bus.req1_sel = sel[0]; end
      @(negedge clk);
      check("op_ready", id ? bus.req1_ready : bus.req0_ready, 1);
      @(posedge clk); #1;
      bus.req0_valid = 0; bus.req1_valid = 0;
      @(negedge clk);
      check("op_exec_nvld", bus.rsp_valid, 0);
      @(negedge clk);
      check("op_vld", bus.rsp_valid, 1);
      check("op_id", bus.rsp_id, id);
      check("op_out", bus.rsp_out, eo);
      check("op_cob", bus.rsp_cob, ec);
      step(1);
   endtask

   initial begin
      logic [7:0] f_out;
      int k;
      rst_n = 0;
      {bus.req0_valid, bus.req1_valid, bus.req0_sel, bus.req1_sel} = 0;
      {bus.req0_a, bus.req0_b, bus.req1_a, bus.req1_b} = 0;
      bus.rsp_ready = 1;
      {bus2.req0_valid, bus2.req1_valid, bus2.req0_sel, bus2.req1_sel} = 0;
      {bus2.req0_a, bus2.req0_b, bus2.req1_a, bus2.req1_b} = 0;
      bus2.rsp_ready = 1;
      #1;
      reset_dut();
      step(1);
      do_op(0, 5, 9, 0, 14, 0);
      do_op(1, 3, 7, 1, 12, 1);
      do_op(0, 15, 1, 0, 0, 1);

      reset_dut();
      log_q.delete();
      bus.req0_valid = 1; bus.req1_valid = 1;
      bus.req0_a = 2; bus.req0_b = 3; bus.req1_a = 9; bus.req1_b = 4; bus.req1_sel = 1;
      for (int c = 0; c < 40 && log_q.size() < 4; c++) step(1);
      bus.req0_valid = 0; bus.req1_valid = 0;
      check("cont_done", log_q.size(), 4);
      if (log_q.size() >= 4) check("cont_order", {log_q[0][0], log_q[1][0], log_q[2][0], log_q[3][0]}, 4'b0101);
      check("cont_cnt", {cnt0, cnt1}, {8'd2, 8'd2});
      step(2);

      bus.rsp_ready = 0; bus.req0_valid = 1; bus.req1_valid = 1;
      k = 0;
      while (!bus.rsp_valid && k < 10) begin step(1); k++; end
      check("bp_reach", bus.rsp_valid, 1);
      f_out = {2'b0, bus.rsp_id, bus.rsp_cob, bus.rsp_out};
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("bp_rdy", {bus.req1_ready, bus.req0_ready}, 0);
         check("bp_hold", {2'b0, bus.rsp_id, bus.rsp_cob, bus.rsp_out}, f_out);
         check("bp_cnt", {cnt0, cnt1}, {8'd3, 8'd2});
      end
      @(posedge clk); #1;
      bus.rsp_ready = 1; bus.req0_valid = 0; bus.req1_valid = 0;
      step(3);

      do_op(0, 1, 2, 0, 3, 0);
      bus.req1_valid = 1; bus.req1_a = 2; bus.req1_b = 2;
      @(negedge clk);
      check("rx_rdy1", bus.req1_ready, 1);
      @(posedge clk); #1;
      bus.req1_valid = 0;
      #2 rst_n = 0;
      #1;
      check("rx_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_cob, bus.rsp_out}, 0);
      check("rx_acs", {bus.acs_sel, bus.acs_a, bus.acs_b}, 0);
      check("rx_cnt", {cnt0, cnt1}, 0);
      step(1);
      rst_n = 1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("rx_no_rsp", bus.rsp_valid, 0);
      end
      @(posedge clk); #1;
      bus.req0_valid = 1; bus.req1_valid = 1;
      @(negedge clk);
      check("rx_grant0", {bus.req1_ready, bus.req0_ready}, 2'b01);
      @(posedge clk); #1;
      bus.req0_valid = 0; bus.req1_valid = 0;
      step(4);

      for (int c = 0; c < 300; c++) begin
         bus.req0_valid = 1'($urandom_range(0, 1));
         bus.req1_valid = 1'($urandom_range(0, 1));
         bus.req0_a = 4'($urandom); bus.req0_b = 4'($urandom); bus.req0_sel = 1'($urandom);
         bus.req1_a = 4'($urandom); bus.req1_b = 4'($urandom); bus.req1_sel = 1'($urandom);
         bus.rsp_ready = $urandom_range(0, 3) != 0;
         step(1);
      end
      bus.req0_valid = 0; bus.req1_valid = 0; bus.rsp_ready = 1;
      step(5);

      bus2.req0_valid = 1; bus2.req0_a = 1; bus2.req0_b = 1;
      k = 0;
      for (int c = 0; c < 60 && k < 5; c++) begin
         @(negedge clk);
         if (bus2.req0_ready) begin
            k++;
            @(posedge clk); #1;
            if (k == 5) bus2.req0_valid = 0;
            check("sat_cnt", s_cnt0, k > 3 ? 3 : k);
         end
      end
      check("sat_accepts", k, 5);
      step(6);
      check("sat_final", {s_cnt0, s_cnt1}, 4'b1100);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/acs_scheduler.md
ACS_SCHEDULER -- requirements
Module: acs_scheduler

Interface
REQ-001 Parameter: W, default 4, operand/result width shared with the add/sub unit.
REQ-002 Parameter: CNT_W, default 8, width of per-requester grant counters.
REQ-003 Ports, clock and reset first:
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid / req1_valid  in  1  requester N has an operation pending.
- req0_a, req0_b / req1_a, req1_b  in  W  operands.
- req0_sel / req1_sel  in  1  0 = add, 1 = subtract.
- req0_ready / req1_ready  out  1  operation accepted this cycle.
- acs_a, acs_b  out  W  operands driven to the shared add/sub unit.
- acs_sel  out  1  mode driven to the shared unit.
- acs_out  in  W  result from the shared unit (combinational).
- acs_cob  in  1  carry/borrow from the shared unit.
- rsp_valid  out  1  response held.
- rsp_id  out  1  requester that owns the response.
- rsp_out  out  W  result.
- rsp_cob  out  1  carry (add) or borrow (subtract).
- rsp_ready  in  1  consumer takes the response.
- gnt_cnt0 / gnt_cnt1  out  CNT_W  accepted operations per requester.

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, EXEC, RESP.
REQ-005 In IDLE with any reqN_valid high, the block SHALL assert reqN_ready for exactly one winner (combinational from valids, IDLE only), latch its a/b/sel/id, and enter EXEC.
REQ-006 Arbitration SHALL be round-robin: pointer names the preferred requester; the other wins only when the preferred one is idle.
REQ-007 After each response handshake, the pointer SHALL move to the requester not just served.
REQ-008 reqN_ready SHALL be low in EXEC and RESP.
REQ-009 In EXEC, acs_a/acs_b/acs_sel SHALL carry the latched operands; acs_out/acs_cob SHALL be registered into rsp_out/rsp_cob at the end of that cycle; next state RESP.
REQ-010 Outside EXEC, acs_a/acs_b/acs_sel SHALL hold the last latched values (no toggling).
REQ-011 In RESP, rsp_valid SHALL be high and rsp_id/rsp_out/rsp_cob stable until rsp_valid && rsp_ready; then IDLE.
REQ-012 Latency: accept at edge N -> rsp_valid high from cycle N+2; with rsp_ready tied high, one operation per 3 cycles.
REQ-013 gnt_cntN SHALL increment on each reqN acceptance and saturate at 2^CNT_W-1.
REQ-014 Bench model of the shared unit: add {cob,out}=a+b; subtract out=(a-b) mod 2^W, cob=1 iff a<b.

Reset
REQ-015 rst_n low SHALL immediately force state IDLE, pointer=0, rsp_valid=0, rsp_id=0, rsp_out=0, rsp_cob=0, acs_a=0, acs_b=0, acs_sel=0, gnt_cnt0=gnt_cnt1=0, independent of clk.
REQ-016 Reset mid-EXEC or mid-RESP SHALL drop the in-flight operation with no response.
REQ-017 reqN_ready SHALL be 0 while rst_n is low.

Structure
REQ-018 State encoding (IDLE/EXEC/RESP) and default W SHALL live in shared package acs_pkg.
REQ-019 The round-robin pick SHALL be a sub-module rr_arb2 (valids, pointer -> one-hot grant); the add/sub unit SHALL stay external.

Verification
REQ-020 Single add: req0 a=5 b=9 sel=0, rsp_ready=1 -> rsp_valid at N+2, rsp_id=0, rsp_out=14, rsp_cob=0.
REQ-021 Subtract with borrow: req1 a=3 b=7 sel=1 -> rsp_id=1, rsp_out=12, rsp_cob=1; add overflow a=15 b=1 -> out=0, cob=1.
REQ-022 Contention: both valid continuously after reset -> grants 0,1,0,1; gnt_cnt0=gnt_cnt1=2 after four responses.
REQ-023 Backpressure: rsp_ready low 5 cycles in RESP -> rsp fields stable, both reqN_ready low, no new acceptance until handshake.
REQ-024 Reset in EXEC: rst_n low mid-operation -> all outputs zero at once, no rsp_valid after release, next grant goes to req0.
REQ-025 Saturation: CNT_W=2, five req0 operations -> gnt_cnt0 stops at 3.
